signal_composer_n: RTL and testbench
====================================

SIGNAL_COMPOSER_N -- requirements
Module: signal_composer_n

Interface
REQ-001 Parameter N_CH, default 4: number of waveform channels summed, legal range 1..8.
REQ-002 Parameter IN_W, default 16: width of each signed channel, seq and offset input.
REQ-003 Parameter OUT_W, default 16: width of the signed saturated output.
REQ-004 Parameter RAMP_W, default 8: ramp resolution; unity gain = 2^RAMP_W, full ramp = 2^RAMP_W cycles.
REQ-005 The block SHALL have one clock, clk, and a synchronous, active-low reset, aresetn, sampled on the rising edge of clk.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 aresetn  input  1  synchronous active-low reset.
REQ-008 wave  input  N_CH*IN_W  packed signed channel samples; channel k = bits [k*IN_W +: IN_W].
REQ-009 valid  input  N_CH  per-channel sample valid.
REQ-010 ch_enable  input  N_CH  per-channel enable; a disabled channel contributes 0 and its valid is ignored.
REQ-011 seq  input  IN_W  signed sequence value added to the sum.
REQ-012 offset  input  IN_W  signed DC offset added to the sum.
REQ-013 disable_dac  input  1  level request to ramp the output to 0 (high) or back to unity (low).
REQ-014 clear_sat  input  1  single-cycle pulse that clears sat_flag.
REQ-015 signal_out  output  OUT_W  signed, scaled, saturated result.
REQ-016 signal_valid  output  1  qualifies signal_out.
REQ-017 sat_flag  output  1  sticky flag: saturation has occurred.
REQ-018 ramp_busy  output  1  high in RAMP_DOWN or RAMP_UP.
REQ-019 dac_off  output  1  high in OFF.

Function
REQ-020 Internal sum width SHALL be IN_W + clog2(N_CH+2) + 1 bits so no intermediate overflow occurs; all adds are sign-extended.
REQ-021 Pipeline: 1 input register (masked samples, masked valid), D = clog2(N_CH) registered adder-tree levels (D = 0 for N_CH = 1), 1 stage adding the registered seq+offset, 1 scale stage, and 1 saturate/output register.
REQ-022 Total latency from input sample to signal_out SHALL be D+4 cycles for every N_CH; seq and offset SHALL be delayed to stay aligned with the wave samples.
REQ-023 signal_valid SHALL be the AND of valid[k] over enabled channels, delayed by D+4 cycles; with ch_enable = 0, valid is 1 and the sum is seq+offset.
REQ-024 Scale stage: product = sum * scale, arithmetically right-shifted by RAMP_W (floor toward minus infinity); scale ranges 0..2^RAMP_W.
REQ-025 Saturation: a result above 2^(OUT_W-1)-1 SHALL clamp to that value; a result below -2^(OUT_W-1) SHALL clamp to that value; either clamp sets sat_flag in the same cycle signal_out updates.
REQ-026 sat_flag SHALL stay high until a clear_sat pulse; if a clamp and clear_sat occur in the same cycle, the set wins.
REQ-027 Ramp FSM states: OFF (scale = 0), RAMP_UP (scale +1 per cycle), ON (scale = 2^RAMP_W), RAMP_DOWN (scale -1 per cycle).
REQ-028 Transitions: OFF->RAMP_UP when disable_dac = 0. RAMP_UP->ON when scale reaches 2^RAMP_W. ON->RAMP_DOWN when disable_dac = 1. RAMP_DOWN->OFF when scale reaches 0.
REQ-029 Reversal: disable_dac = 1 in RAMP_UP -> RAMP_DOWN from the current scale; disable_dac = 0 in RAMP_DOWN -> RAMP_UP from the current scale; no jump in scale.
REQ-030 The scale register SHALL feed the scale stage directly; the scale change takes effect at signal_out 2 cycles later.
REQ-031 Changes to ch_enable SHALL take effect at the input register; no flush is performed.

Reset
REQ-032 While aresetn = 0: all pipeline registers = 0, signal_out = 0, signal_valid = 0, sat_flag = 0, FSM = OFF, scale = 0, dac_off = 1, ramp_busy = 0.
REQ-033 After release with disable_dac = 0, the FSM SHALL ramp up from 0; a reset mid-ramp SHALL return the FSM to OFF immediately.

Verification (N_CH=4, IN_W=16, OUT_W=16, RAMP_W=4, D=2)
REQ-034 Reset release, disable_dac = 0 -> dac_off falls next cycle, ramp_busy high 16 cycles, then FSM reaches ON.
REQ-035 ON, waves 1000/2000/3000/4000, seq = 100, offset = -50, all valid -> signal_out = 10050 exactly 6 cycles later, signal_valid = 1.
REQ-036 All waves = 32767, seq = offset = 32767 -> signal_out = 32767, sat_flag = 1. All inputs = -32768 -> signal_out = -32768. Then clear_sat -> sat_flag = 0 unless saturating that cycle.
REQ-037 ch_enable = 0101, valid = 0101, stimulus as REQ-035 -> signal_out = 4050, signal_valid = 1. Drop valid[0] -> signal_valid = 0 after 6 cycles.
REQ-038 Steady 10050 in ON, assert disable_dac -> output steps down; value 5025 at scale 8; 0 and dac_off = 1 after 16 steps. Deassert at scale 8 during RAMP_DOWN -> RAMP_UP resumes from 8.

Source files
------------

// File: rtl/signal_composer_n.sv
// signal_composer_n: sums N_CH masked waveform channels plus a sequence value
// and a DC offset through a registered adder tree, scales the result by a
// ramped gain (0..2^RAMP_W) and saturates it to OUT_W signed bits.
module signal_composer_n #(
  parameter int N_CH   = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int RAMP_W = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [N_CH*IN_W-1:0]   wave,
  input  logic [N_CH-1:0]        valid,
  input  logic [N_CH-1:0]        ch_enable,
  input  logic [IN_W-1:0]        seq,
  input  logic [IN_W-1:0]        offset,
  input  logic                   disable_dac,
  input  logic                   clear_sat,
  output logic [OUT_W-1:0]       signal_out,
  output logic                   signal_valid,
  output logic                   sat_flag,
  output logic                   ramp_busy,
  output logic                   dac_off
);

  // Adder-tree depth; the leaf count is padded up to a power of two.
  localparam int D      = $clog2(N_CH);
  localparam int P      = 1 << D;
  // Wide enough to hold N_CH channels plus seq and offset without overflow.
  localparam int SUM_W  = IN_W + $clog2(N_CH + 2) + 1;
  localparam int PROD_W = SUM_W + RAMP_W + 2;
  localparam int SC_W   = RAMP_W + 1;

  localparam logic [SC_W-1:0] SCALE_FULL = {1'b1, {RAMP_W{1'b0}}};
  localparam logic [SC_W-1:0] SCALE_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0] SCALE_TOP1 = SCALE_FULL - SCALE_ONE;

  localparam logic signed [PROD_W-1:0] OUT_MAX =
    {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] OUT_MIN =
    {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [SC_W-1:0] scale_reg, scale_next;

  // ---------------------------------------------------------------- ramp FSM

  // State and scale register.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_reg <= ST_OFF;
      scale_reg <= '0;
    end else begin
      state_reg <= state_next;
      scale_reg <= scale_next;
    end
  end

  // Next state and scale; a reversal holds the scale for one cycle so the
  // gain never jumps, then steps from where it was.
  always_comb begin
    state_next = state_reg;
    scale_next = scale_reg;
    case (state_reg)
      ST_OFF: begin
        scale_next = '0;
        if (!disable_dac) state_next = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (disable_dac) begin
          state_next = ST_RAMP_DOWN;
        end else if (scale_reg == SCALE_FULL) begin
          state_next = ST_ON;
        end else begin
          scale_next = scale_reg + SCALE_ONE;
          if (scale_reg == SCALE_TOP1) state_next = ST_ON;
        end
      end
      ST_ON: begin
        scale_next = SCALE_FULL;
        if (disable_dac) state_next = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (!disable_dac) begin
          state_next = ST_RAMP_UP;
        end else if (scale_reg == '0) begin
          state_next = ST_OFF;
        end else begin
          scale_next = scale_reg - SCALE_ONE;
          if (scale_reg == SCALE_ONE) state_next = ST_OFF;
        end
      end
      default: begin
        state_next = ST_OFF;
        scale_next = '0;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    ramp_busy = (state_reg == ST_RAMP_UP) || (state_reg == ST_RAMP_DOWN);
    dac_off   = (state_reg == ST_OFF);
  end

  // ---------------------------------------------------------------- datapath

  logic [P*IN_W-1:0] wave_pad;
  logic [P-1:0]      en_pad;

  // Pad channel inputs to the power-of-two leaf count; pad leaves are disabled.
  always_comb begin
    wave_pad              = '0;
    en_pad                = '0;
    wave_pad[N_CH*IN_W-1:0] = wave;
    en_pad[N_CH-1:0]      = ch_enable;
  end

  // Valid and seq+offset travel alongside the tree so they stay aligned.
  logic                    vld_d [D+1];
  logic signed [SUM_W-1:0] so_d  [D+1];

  // Input stage for valid / seq+offset, then a D-deep delay line.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int k = 0; k <= D; k++) begin
        vld_d[k] <= 1'b0;
        so_d[k]  <= '0;
      end
    end else begin
      vld_d[0] <= &(valid | ~ch_enable);
      so_d[0]  <= SUM_W'($signed(seq)) + SUM_W'($signed(offset));
      for (int k = 1; k <= D; k++) begin
        vld_d[k] <= vld_d[k-1];
        so_d[k]  <= so_d[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= D; gi++) begin : lvl
      localparam int NN = P >> gi;
      logic signed [SUM_W-1:0] node [NN];
      if (gi == 0) begin : g_leaf
        // Input register: masked, sign-extended channel samples.
        always_ff @(posedge clk) begin
          if (!aresetn) begin
            for (int k = 0; k < NN; k++) node[k] <= '0;
          end else begin
            for (int k = 0; k < NN; k++)
              node[k] <= en_pad[k] ? SUM_W'($signed(wave_pad[k*IN_W +: IN_W])) : '0;
          end
        end
      end else begin : g_add
        // One registered level of pairwise adds.
        always_ff @(posedge clk) begin
          if (!aresetn) begin
            for (int k = 0; k < NN; k++) node[k] <= '0;
          end else begin
            for (int k = 0; k < NN; k++)
              node[k] <= lvl[gi-1].node[2*k] + lvl[gi-1].node[2*k+1];
          end
        end
      end
    end
  endgenerate

  logic signed [SUM_W-1:0]  sum_reg;
  logic                     sum_vld_reg;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [PROD_W-1:0] scaled_reg, scaled_next;
  logic                     scaled_vld_reg;

  // Tree result plus the aligned seq+offset.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      sum_reg     <= '0;
      sum_vld_reg <= 1'b0;
    end else begin
      sum_reg     <= lvl[D].node[0] + so_d[D];
      sum_vld_reg <= vld_d[D];
    end
  end

  // Gain multiply; the arithmetic shift floors toward minus infinity.
  always_comb begin
    prod_full   = PROD_W'(sum_reg) * PROD_W'($signed({1'b0, scale_reg}));
    scaled_next = prod_full >>> RAMP_W;
  end

  // Scale stage register, fed directly by the live scale register.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      scaled_reg     <= '0;
      scaled_vld_reg <= 1'b0;
    end else begin
      scaled_reg     <= scaled_next;
      scaled_vld_reg <= sum_vld_reg;
    end
  end

  logic [OUT_W-1:0] out_next, out_reg;
  logic             sat_hit, sat_next, sat_reg, out_vld_reg;

  // Clamp to the signed output range; a clamp beats a same-cycle clear.
  always_comb begin
    sat_hit  = 1'b0;
    out_next = scaled_reg[OUT_W-1:0];
    if (scaled_reg > OUT_MAX) begin
      out_next = OUT_MAX[OUT_W-1:0];
      sat_hit  = 1'b1;
    end else if (scaled_reg < OUT_MIN) begin
      out_next = OUT_MIN[OUT_W-1:0];
      sat_hit  = 1'b1;
    end
    sat_next = sat_hit | (sat_reg & ~clear_sat);
  end

  // Output register and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      out_reg     <= '0;
      out_vld_reg <= 1'b0;
      sat_reg     <= 1'b0;
    end else begin
      out_reg     <= out_next;
      out_vld_reg <= scaled_vld_reg;
      sat_reg     <= sat_next;
    end
  end

  assign signal_out   = out_reg;
  assign signal_valid = out_vld_reg;
  assign sat_flag     = sat_reg;

endmodule

// File: tb/tb_signal_composer_n.sv
// Directed bench for signal_composer_n with N_CH=4, IN_W=16, OUT_W=16,
// RAMP_W=4 (pipeline latency 6, full ramp 16 cycles).
module tb_signal_composer_n;

  logic               clk = 1'b0;
  logic               aresetn;
  logic [63:0]        wave;
  logic [3:0]         valid;
  logic [3:0]         ch_enable;
  logic [15:0]        seq;
  logic [15:0]        offset;
  logic               disable_dac;
  logic               clear_sat;
  logic signed [15:0] signal_out;
  logic               signal_valid;
  logic               sat_flag;
  logic               ramp_busy;
  logic               dac_off;

  int tests_run    = 0;
  int tests_failed = 0;

  signal_composer_n #(.N_CH(4), .IN_W(16), .OUT_W(16), .RAMP_W(4)) dut (
    .clk(clk), .aresetn(aresetn), .wave(wave), .valid(valid),
    .ch_enable(ch_enable), .seq(seq), .offset(offset),
    .disable_dac(disable_dac), .clear_sat(clear_sat),
    .signal_out(signal_out), .signal_valid(signal_valid),
    .sat_flag(sat_flag), .ramp_busy(ramp_busy), .dac_off(dac_off)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [15:0] w0, w1, w2, w3, s, o,
                       input logic [3:0] en, v);
    wave      = {w3, w2, w1, w0};
    seq       = s;
    offset    = o;
    ch_enable = en;
    valid     = v;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; disable_dac = 1'b1; clear_sat = 1'b0;
    drive(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'hF, 4'hF);
    tick(3);
    tests_run++;
    if (signal_out !== 16'sd0 || signal_valid !== 1'b0 || sat_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data: out=%0d valid=%b sat=%b required 0/0/0", signal_out, signal_valid, sat_flag);
    end
    tests_run++;
    if (dac_off !== 1'b1 || ramp_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fsm: dac_off=%b busy=%b required 1/0", dac_off, ramp_busy);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_ramp_up();
    int cnt = 0;
    disable_dac = 1'b0;
    aresetn = 1'b1;
    tick();
    tests_run++;
    if (dac_off !== 1'b0) begin
      tests_failed++;
      $display("FAIL ramp_up_dac_off: got %b required 0", dac_off);
    end
    for (int i = 0; i < 100 && ramp_busy; i++) begin
      cnt++;
      tick();
    end
    tests_run++;
    if (cnt != 16 || dac_off !== 1'b0 || ramp_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ramp_up_len: busy_cycles=%0d dac_off=%b required 16 cycles then ON", cnt, dac_off);
    end
    $display("[TB] test_ramp_up busy_cycles=%0d", cnt);
  endtask

  task automatic test_sum_latency();
    drive(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'hF, 4'hF);
    tick(8);
    drive(16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd100, -16'sd50, 4'hF, 4'hF);
    tick(5);
    tests_run++;
    if (signal_out !== 16'sd0) begin
      tests_failed++;
      $display("FAIL sum_early: got %0d required 0 after 5 cycles", signal_out);
    end
    tick();
    tests_run++;
    if (signal_out !== 16'sd10050 || signal_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sum_basic: got %0d valid=%b required 10050 valid=1", signal_out, signal_valid);
    end
    $display("[TB] test_sum_latency out=%0d", signal_out);
  endtask

  task automatic test_ch_enable();
    drive(16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd100, -16'sd50, 4'b0101, 4'b0101);
    tick(6);
    tests_run++;
    if (signal_out !== 16'sd4050 || signal_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL enable_mask: got %0d valid=%b required 4050 valid=1", signal_out, signal_valid);
    end
    valid = 4'b0100;
    tick(5);
    tests_run++;
    if (signal_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL valid_early: got %b required 1 after 5 cycles", signal_valid);
    end
    tick();
    tests_run++;
    if (signal_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_drop: got %b required 0", signal_valid);
    end
    drive(16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd100, -16'sd50, 4'b0000, 4'b0000);
    tick(6);
    tests_run++;
    if (signal_out !== 16'sd50 || signal_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL all_disabled: got %0d valid=%b required 50 valid=1", signal_out, signal_valid);
    end
    $display("[TB] test_ch_enable done");
  endtask

  task automatic test_saturation();
    tests_run++;
    if (sat_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_idle: got %b required 0", sat_flag);
    end
    drive(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'hF, 4'hF);
    tick(6);
    tests_run++;
    if (signal_out !== 16'sd32767 || sat_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_pos: got %0d sat=%b required 32767 sat=1", signal_out, sat_flag);
    end
    drive(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'hF, 4'hF);
    tick(6);
    tests_run++;
    if (signal_out !== -16'sd32768) begin
      tests_failed++;
      $display("FAIL sat_neg: got %0d required -32768", signal_out);
    end
    clear_sat = 1'b1;
    tick();
    clear_sat = 1'b0;
    tests_run++;
    if (sat_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_set_wins: got %b required 1", sat_flag);
    end
    drive(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'hF, 4'hF);
    tick(6);
    tests_run++;
    if (signal_out !== 16'sd0 || sat_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_sticky: got %0d sat=%b required 0 sat=1", signal_out, sat_flag);
    end
    clear_sat = 1'b1;
    tick();
    clear_sat = 1'b0;
    tests_run++;
    if (sat_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_clear: got %b required 0", sat_flag);
    end
    $display("[TB] test_saturation done");
  endtask

  task automatic test_ramp_down();
    drive(16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd100, -16'sd50, 4'hF, 4'hF);
    tick(6);
    tests_run++;
    if (signal_out !== 16'sd10050) begin
      tests_failed++;
      $display("FAIL ramp_pre: got %0d required 10050", signal_out);
    end
    disable_dac = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 1) begin
        tests_run++;
        if (ramp_busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL ramp_down_start: busy=%b required 1", ramp_busy);
        end
      end
      if (k == 10) begin
        tests_run++;
        if (signal_out !== 16'sd5653) begin
          tests_failed++;
          $display("FAIL ramp_down_s9: got %0d required 5653", signal_out);
        end
      end
      if (k == 11) begin
        tests_run++;
        if (signal_out !== 16'sd5025) begin
          tests_failed++;
          $display("FAIL ramp_down_s8: got %0d required 5025", signal_out);
        end
      end
      if (k == 16) begin
        tests_run++;
        if (dac_off !== 1'b0 || ramp_busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL ramp_down_s1: dac_off=%b busy=%b required 0/1", dac_off, ramp_busy);
        end
      end
      if (k == 17) begin
        tests_run++;
        if (dac_off !== 1'b1 || ramp_busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL ramp_down_off: dac_off=%b busy=%b required 1/0", dac_off, ramp_busy);
        end
      end
      if (k == 19) begin
        tests_run++;
        if (signal_out !== 16'sd0) begin
          tests_failed++;
          $display("FAIL ramp_down_zero: got %0d required 0", signal_out);
        end
      end
    end
    $display("[TB] test_ramp_down done");
  endtask

  task automatic test_reversal();
    disable_dac = 1'b0;
    tick();
    for (int i = 0; i < 100 && ramp_busy; i++) tick();
    tick(2);
    tests_run++;
    if (signal_out !== 16'sd10050 || dac_off !== 1'b0) begin
      tests_failed++;
      $display("FAIL rev_on: got %0d dac_off=%b required 10050/0", signal_out, dac_off);
    end
    disable_dac = 1'b1;
    tick(9);
    disable_dac = 1'b0;
    tick();
    tests_run++;
    if (ramp_busy !== 1'b1 || dac_off !== 1'b0) begin
      tests_failed++;
      $display("FAIL rev_busy: busy=%b dac_off=%b required 1/0", ramp_busy, dac_off);
    end
    tick(2);
    tests_run++;
    if (signal_out !== 16'sd5025) begin
      tests_failed++;
      $display("FAIL rev_hold8: got %0d required 5025", signal_out);
    end
    tick();
    tests_run++;
    if (signal_out !== 16'sd5653) begin
      tests_failed++;
      $display("FAIL rev_step9: got %0d required 5653", signal_out);
    end
    for (int i = 0; i < 100 && ramp_busy; i++) tick();
    tick(2);
    tests_run++;
    if (signal_out !== 16'sd10050 || ramp_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rev_back_on: got %0d busy=%b required 10050/0", signal_out, ramp_busy);
    end
    $display("[TB] test_reversal done");
  endtask

  task automatic test_reset_midramp();
    disable_dac = 1'b1;
    tick(5);
    tests_run++;
    if (ramp_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_busy: got %b required 1", ramp_busy);
    end
    aresetn = 1'b0;
    tick();
    tests_run++;
    if (dac_off !== 1'b1 || ramp_busy !== 1'b0 || signal_out !== 16'sd0 || signal_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: dac_off=%b busy=%b out=%0d valid=%b required 1/0/0/0",
               dac_off, ramp_busy, signal_out, signal_valid);
    end
    aresetn = 1'b1;
    tick(2);
    tests_run++;
    if (dac_off !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_stay_off: got %b required 1", dac_off);
    end
    $display("[TB] test_reset_midramp done");
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_sum_latency();
    test_ch_enable();
    test_saturation();
    test_ramp_down();
    test_reversal();
    test_reset_midramp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
